// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: unit identifiers, CDB slot entry type and default latencies
// shared by the issue unit, dispatcher and CDB mux.
package issue_unit_pkg;

    typedef enum logic [1:0] {
        UNIT_INT   = 2'd0,
        UNIT_LD_SW = 2'd1,
        UNIT_MULT  = 2'd2,
        UNIT_DIV   = 2'd3
    } unit_id_e;

    typedef struct packed {
        logic     valid;
        unit_id_e id;
    } slot_t;

    localparam int DEF_INT_LAT   = 1;
    localparam int DEF_LD_SW_LAT = 1;
    localparam int DEF_MULT_LAT  = 4;
    localparam int DEF_DIV_LAT   = 7;

endpackage

// File: rtl/issue_unit_slot_shifter.sv
// cdb_slot_shifter: CDB reservation register; shifts toward the head every cycle,
// inserts a grant at its latency slot and reports which units' slots are free.
module cdb_slot_shifter
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT   = DEF_INT_LAT,
    parameter int LD_SW_LAT = DEF_LD_SW_LAT,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int DIV_LAT   = DEF_DIV_LAT
)(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ins_en_i,
    input  unit_id_e   ins_id_i,
    output logic [3:0] free_o,
    output slot_t      head_o
);
    localparam int LAT [4] = '{INT_LAT, LD_SW_LAT, MULT_LAT, DIV_LAT};

    slot_t [DIV_LAT-1:0] r_q;
    slot_t [DIV_LAT-1:0] r_d;

    for (genvar g = 0; g < DIV_LAT; g++) begin : g_slot
        slot_t nxt;
        if (g == DIV_LAT - 1) begin : g_last
            assign nxt = '0;
        end else begin : g_mid
            assign nxt = r_q[g+1];
        end
        assign r_d[g] = (ins_en_i && LAT[ins_id_i] == g + 1) ? slot_t'{valid: 1'b1, id: ins_id_i} : nxt;
    end

    // Eligibility looks at the pre-shift slot L; the slot past the end is always free.
    for (genvar u = 0; u < 4; u++) begin : g_free
        if (LAT[u] >= DIV_LAT) begin : g_edge
            assign free_o[u] = 1'b1;
        end else begin : g_look
            assign free_o[u] = !r_q[LAT[u]].valid;
        end
    end

    assign head_o = r_q[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_q <= '0;
        else          r_q <= r_d;
    end

endmodule

// File: rtl/issue_unit.sv
// issue_unit: grants one functional unit per cycle so that every result gets a
// collision-free CDB slot exactly its latency later; tracks the non-pipelined divider.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int INT_LAT   = DEF_INT_LAT,
    parameter int LD_SW_LAT = DEF_LD_SW_LAT,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int DIV_LAT   = DEF_DIV_LAT
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       int_ready,
    input  logic       ld_sw_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    input  logic       i_flush,
    output logic       int_rd,
    output logic       ld_sw_rd,
    output logic       mult_rd,
    output logic       div_rd,
    output logic       cdb_owner_valid,
    output logic [1:0] cdb_owner,
    output logic       div_busy
);
    localparam int CW = $clog2(DIV_LAT + 1);

    if (LD_SW_LAT != INT_LAT) begin : g_lat_eq
        $error("LD_SW_LAT must equal INT_LAT");
    end
    if (INT_LAT < 1 || MULT_LAT < 1 || INT_LAT > DIV_LAT || MULT_LAT > DIV_LAT) begin : g_lat_max
        $error("DIV_LAT must be the largest latency and all latencies at least 1");
    end

    logic [3:0]    free;
    slot_t         head;
    unit_id_e      ins_id;
    logic          ins_en;
    logic          go, pair, int_ok, ld_ok, mult_ok, div_ok;
    logic          rr_q, rr_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;

    cdb_slot_shifter #(
        .INT_LAT   (INT_LAT),
        .LD_SW_LAT (LD_SW_LAT),
        .MULT_LAT  (MULT_LAT),
        .DIV_LAT   (DIV_LAT)
    ) u_shifter (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .ins_en_i (ins_en),
        .ins_id_i (ins_id),
        .free_o   (free),
        .head_o   (head)
    );

    assign div_busy        = div_cnt_q != '0;
    assign cdb_owner_valid = head.valid;
    assign cdb_owner       = head.id;

    // rr_q high means LD_SW is favoured; it only moves when the favoured unit wins.
    always_comb begin
        go        = i_rst_n && !i_flush;
        int_ok    = int_ready && free[UNIT_INT];
        ld_ok     = ld_sw_ready && free[UNIT_LD_SW];
        mult_ok   = mult_ready && free[UNIT_MULT];
        div_ok    = div_ready && free[UNIT_DIV] && !div_busy;
        div_rd    = go && div_ok;
        mult_rd   = go && mult_ok && !div_ok;
        pair      = go && !div_ok && !mult_ok;
        int_rd    = pair && int_ok && (!rr_q || !ld_ok);
        ld_sw_rd  = pair && ld_ok && (rr_q || !int_ok);
        ins_en    = int_rd || ld_sw_rd || mult_rd || div_rd;
        ins_id    = div_rd ? UNIT_DIV : mult_rd ? UNIT_MULT : ld_sw_rd ? UNIT_LD_SW : UNIT_INT;
        rr_d      = ld_sw_rd ? 1'b0 : int_rd ? 1'b1 : rr_q;
        div_cnt_d = div_rd ? CW'(DIV_LAT - 1) : div_cnt_q - CW'(div_busy);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q      <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            rr_q      <= rr_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter INT_LAT, default 1, cycles from int_rd issue to CDB ownership by the integer unit.
REQ-002 Parameter LD_SW_LAT, default 1, same for load/store unit; SHALL equal INT_LAT (elaboration-time check).
REQ-003 Parameter MULT_LAT, default 4, multiplier latency; multiplier fully pipelined.
REQ-004 Parameter DIV_LAT, default 7, divider latency; divider non-pipelined; DIV_LAT is the largest latency and sets slot depth.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 int_ready / ld_sw_ready / mult_ready / div_ready  in  1 each  issue queue holds a ready instruction.
REQ-008 i_flush  in  1  branch-mispredict flush from the dispatcher.
REQ-009 int_rd / ld_sw_rd / mult_rd / div_rd  out  1 each  one-cycle grant; queue pops its head on that cycle.
REQ-010 cdb_owner_valid  out  1  a functional unit drives the CDB this cycle.
REQ-011 cdb_owner  out  2  CDB mux select: 0 INT, 1 LD_SW, 2 MULT, 3 DIV.
REQ-012 div_busy  out  1  divider occupied; no div issue.

Function
REQ-013 At most one rd output SHALL be high per cycle; rd outputs are combinational from ready inputs and registered state.
REQ-014 Slot register r[0..DIV_LAT-1], each entry {valid, unit id}; r[0] drives cdb_owner_valid/cdb_owner directly.
REQ-015 Every edge: r[k] <= r[k+1], r[DIV_LAT-1] <= empty; then the granted unit with latency L writes r[L-1] <= {1, id}.
REQ-016 Unit with latency L eligible iff its ready is high and pre-shift r[L] is empty (r[DIV_LAT] treated empty), so a grant at cycle T yields cdb_owner = unit at exactly T+L.
REQ-017 Divider additionally eligible only when div_busy = 0.
REQ-018 Grant priority among eligible units: DIV > MULT > (INT/LD_SW round-robin); long-latency starvation of INT/LD_SW is accepted, bounded by queue depth.
REQ-019 Round-robin bit: reset favours INT; toggles only when INT or LD_SW is granted; when the favoured unit is ineligible the other is granted without toggling the preference rule.
REQ-020 Div counter loads DIV_LAT-1 on div grant, decrements when nonzero; div_busy = (counter != 0); a new div may issue in the same cycle the prior div result owns the CDB.
REQ-021 i_flush high: all rd outputs forced 0 that cycle; slot register and div counter continue unchanged (in-flight results still reach CDB, discarded downstream by tag).
REQ-022 No grant when no unit eligible; slot shift continues every cycle regardless.

Reset
REQ-023 While i_rst_n low: all r entries invalid, counter 0, RR bit = INT, all rd outputs 0, cdb_owner_valid 0, cdb_owner 0, div_busy 0.
REQ-024 Reset mid-operation SHALL discard all reservations immediately; first grant possible the cycle after deassertion.

Structure
REQ-025 Shared package holds unit-id enum (INT, LD_SW, MULT, DIV) and default latency constants; the dispatcher and CDB mux import it.
REQ-026 One sub-module, cdb_slot_shifter, holds r[] with shift/insert/lookup; grant logic and div counter stay in issue_unit.

Verification
REQ-027 int_ready high T0..T2 only -> int_rd T0,T1,T2; cdb_owner_valid=1, cdb_owner=0 at T1..T3.
REQ-028 mult_ready T0 only, int_ready continuous from T0 -> mult_rd T0; int_rd T1,T2, 0 at T3 (slot T4 taken), 1 from T4; cdb_owner=2 at T4.
REQ-029 div_ready continuous T0..T10 -> div_rd T0 and T7 only; div_busy high T1..T6; cdb_owner=3 at T7.
REQ-030 int_ready and ld_sw_ready continuous from T0 -> int_rd T0,T2; ld_sw_rd T1,T3; owners alternate 0,1 from T1.
REQ-031 mult grant T-1, then i_flush=1 with mult_ready=1 at T0 -> all rd 0 at T0; mult_rd T1; cdb_owner=2 at T3 and T5.
REQ-032 div grant T0, i_rst_n low at T2 -> outputs 0 and div_busy 0 immediately; after release div_ready=1 -> div_rd next cycle; no stale CDB ownership at T7.
